// File: rtl/tis_pkg.sv
// Shared constants for a TIS-100 node: opcodes, next-address select codes,
// program-fetch FSM states and the jump-target clamp helper.
package tis_pkg;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_JMP = 5'h08;
  localparam logic [4:0] OP_JEZ = 5'h09;
  localparam logic [4:0] OP_JNZ = 5'h0A;
  localparam logic [4:0] OP_JGZ = 5'h0B;
  localparam logic [4:0] OP_JLZ = 5'h0C;
  localparam logic [4:0] OP_JRO = 5'h0D;

  localparam logic [1:0] JC_INC  = 2'b00;
  localparam logic [1:0] JC_ABS  = 2'b01;
  localparam logic [1:0] JC_IMM  = 2'b10;
  localparam logic [1:0] JC_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Clamp a signed candidate address into [0, len-1]; len is never 0 in RUN.
  function automatic logic [7:0] clamp_addr(input logic signed [9:0] x,
                                            input logic [8:0] len);
    logic signed [10:0] xe;
    logic signed [10:0] lim;
    xe  = {x[9], x};
    lim = $signed({2'b00, len}) - 11'sd1;
    if (xe < 11'sd0)
      return 8'd0;
    else if (xe > lim)
      return lim[7:0];
    else
      return xe[7:0];
  endfunction

endpackage

// File: rtl/jmp_decode.sv
// Combinational next-address decode: evaluates jump opcodes against the
// accumulator, clamps targets to the loaded program and handles wrap/stall.
module jmp_decode
  import tis_pkg::*;
(
  input  logic        run,
  input  logic        stall,
  input  logic [4:0]  opcode,
  input  logic [7:0]  imm,
  input  logic [10:0] acc,
  input  logic [7:0]  addr,
  input  logic [8:0]  len,
  output logic [1:0]  jmp_cond,
  output logic [7:0]  j_addr
);

  logic              acc_zero;
  logic              acc_neg;
  logic              acc_pos;
  logic              cond_true;
  logic              seq_wrap;
  logic signed [9:0] jro_target;
  logic [7:0]        jmp_target;
  logic [7:0]        jro_clamped;

  assign acc_zero = (acc == 11'd0);
  assign acc_neg  = acc[10];
  assign acc_pos  = !acc_zero && !acc_neg;

  // JMP immediates are absolute addresses (unsigned); JRO offsets are signed.
  assign jmp_target  = clamp_addr($signed({2'b00, imm}), len);
  assign jro_target  = $signed({2'b00, addr}) + $signed({{2{imm[7]}}, imm});
  assign jro_clamped = clamp_addr(jro_target, len);
  assign seq_wrap    = (({1'b0, addr} + 9'd1) >= len);

  // Evaluate the conditional-jump predicate for the current opcode.
  always_comb begin
    cond_true = 1'b0;
    case (opcode)
      OP_JEZ:  cond_true = acc_zero;
      OP_JNZ:  cond_true = !acc_zero;
      OP_JGZ:  cond_true = acc_pos;
      OP_JLZ:  cond_true = acc_neg;
      default: cond_true = 1'b0;
    endcase
  end

  // Priority select: stall hold, taken jump, relative jump, then sequential.
  always_comb begin
    jmp_cond = JC_ZERO;
    j_addr   = 8'd0;
    if (run) begin
      if (stall) begin
        jmp_cond = JC_ABS;
        j_addr   = addr;
      end else if ((opcode == OP_JMP) || cond_true) begin
        jmp_cond = JC_ABS;
        j_addr   = jmp_target;
      end else if (opcode == OP_JRO) begin
        jmp_cond = JC_ABS;
        j_addr   = jro_clamped;
      end else if (seq_wrap) begin
        jmp_cond = JC_ZERO;
      end else begin
        jmp_cond = JC_INC;
      end
    end
  end

endmodule

// File: rtl/prog_fetch.sv
// Program store for one TIS-100 node: streamed program load, combinational
// instruction fetch at the PC stage's address, and next-address control.
module prog_fetch
  import tis_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [10:0]   acc,
  input  logic          port_stall,
  input  logic [7:0]    Addr_instr,
  output logic [IW-1:0] instr,
  output logic [1:0]    jmpCond,
  output logic [7:0]    jAddr,
  output logic          running,
  output logic [7:0]    prog_len
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] LAST_WP = 8'(DEPTH - 1);

  state_t        state;
  logic [7:0]    wp;
  logic [8:0]    len;
  logic [IW-1:0] mem [DEPTH];
  logic          wr_en;
  logic          load_end;
  logic          in_prog;
  logic [IW-1:0] word;

  // A word written together with load_start is dropped: the new load wins.
  assign wr_en    = (state == ST_LOAD) && load_valid && !load_start;
  assign load_end = wr_en && (load_last || (wp == LAST_WP));

  // Load/run state machine with write pointer and registered program length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      wp    <= 8'd0;
      len   <= 9'd0;
    end else if (load_start) begin
      state <= ST_LOAD;
      wp    <= 8'd0;
      len   <= 9'd0;
    end else if (load_end) begin
      state <= ST_RUN;
      len   <= {1'b0, wp} + 9'd1;
      wp    <= 8'd0;
    end else if (wr_en) begin
      wp <= wp + 8'd1;
    end
  end

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wp[AW-1:0]] <= load_data;
  end

  assign running    = (state == ST_RUN);
  assign load_ready = (state == ST_LOAD);
  assign prog_len   = len[7:0];

  // Addresses past the loaded program read as NOP, as does everything outside RUN.
  assign in_prog = ({1'b0, Addr_instr} < len);
  assign word    = (running && in_prog) ? mem[Addr_instr[AW-1:0]] : '0;
  assign instr   = word;

  jmp_decode u_jmp_decode (
    .run      (running),
    .stall    (port_stall),
    .opcode   (word[4:0]),
    .imm      (word[IW-1:IW-8]),
    .acc      (acc),
    .addr     (Addr_instr),
    .len      (len),
    .jmp_cond (jmpCond),
    .j_addr   (jAddr)
  );

endmodule

// File: tb/tb_prog_fetch.sv
// Self-checking bench for prog_fetch: directed scenarios with literal
// expectations plus randomized load/run traffic against a behavioural model.
module tb_prog_fetch;

  localparam int DEPTH = 16;
  localparam int IW    = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic [10:0]   acc = '0;
  logic          port_stall = 1'b0;
  logic [7:0]    Addr_instr = '0;
  logic [IW-1:0] instr;
  logic [1:0]    jmpCond;
  logic [7:0]    jAddr;
  logic          running;
  logic [7:0]    prog_len;

  prog_fetch #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .acc        (acc),
    .port_stall (port_stall),
    .Addr_instr (Addr_instr),
    .instr      (instr),
    .jmpCond    (jmpCond),
    .jAddr      (jAddr),
    .running    (running),
    .prog_len   (prog_len)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 empty, 1 loading, 2 running
  int            m_mode = 0;
  int            m_wp   = 0;
  int            m_len  = 0;
  logic [IW-1:0] m_mem [DEPTH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_wp   <= 0;
      m_len  <= 0;
    end else if (load_start) begin
      m_mode <= 1;
      m_wp   <= 0;
      m_len  <= 0;
    end else if (m_mode == 1 && load_valid) begin
      m_mem[m_wp] <= load_data;
      if (load_last || m_wp == DEPTH - 1) begin
        m_mode <= 2;
        m_len  <= m_wp + 1;
        m_wp   <= 0;
      end else begin
        m_wp <= m_wp + 1;
      end
    end
  end

  function automatic int clampi(input int x);
    if (x < 0) return 0;
    if (x > m_len - 1) return m_len - 1;
    return x;
  endfunction

  function automatic void model_out(output logic [IW-1:0] e_instr,
                                    output logic [1:0] e_jc,
                                    output logic [7:0] e_ja);
    int              addr;
    int              sacc;
    int              simm;
    logic [4:0]      op;
    logic [7:0]      imm;
    logic signed [7:0] simm8;
    logic signed [10:0] sacc11;
    bit              take;
    e_instr = '0;
    e_jc    = 2'b11;
    e_ja    = 8'd0;
    if (m_mode != 2) return;
    addr   = int'(Addr_instr);
    sacc11 = acc;
    sacc   = int'(sacc11);
    if (addr < m_len) e_instr = m_mem[addr];
    op    = e_instr[4:0];
    imm   = e_instr[17:10];
    simm8 = imm;
    simm  = int'(simm8);
    take  = 1'b0;
    case (op)
      5'h08: take = 1'b1;
      5'h09: take = (sacc == 0);
      5'h0A: take = (sacc != 0);
      5'h0B: take = (sacc > 0);
      5'h0C: take = (sacc < 0);
      default: take = 1'b0;
    endcase
    if (port_stall) begin
      e_jc = 2'b01;
      e_ja = Addr_instr;
    end else if (take) begin
      e_jc = 2'b01;
      e_ja = 8'(clampi(int'(imm)));
    end else if (op == 5'h0D) begin
      e_jc = 2'b01;
      e_ja = 8'(clampi(addr + simm));
    end else if (addr + 1 >= m_len) begin
      e_jc = 2'b11;
    end else begin
      e_jc = 2'b00;
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [IW-1:0] e_instr;
    logic [1:0]    e_jc;
    logic [7:0]    e_ja;
    if (check_en) begin
      model_out(e_instr, e_jc, e_ja);
      chk("cyc_load_ready", 32'(load_ready), 32'(m_mode == 1));
      chk("cyc_running",    32'(running),    32'(m_mode == 2));
      chk("cyc_prog_len",   32'(prog_len),   32'(m_len));
      chk("cyc_instr",      32'(instr),      32'(e_instr));
      chk("cyc_jmpCond",    32'(jmpCond),    32'(e_jc));
      if (e_jc == 2'b01 || m_mode != 2)
        chk("cyc_jAddr", 32'(jAddr), 32'(e_ja));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [IW-1:0] prog[$];
  int            pc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] mk(input logic [4:0] op, input logic [7:0] imm);
    logic [4:0] mid;
    mid = 5'($urandom);
    return {imm, mid, op};
  endfunction

  task automatic load_prog(input bit with_last);
    load_start = 1'b1;
    load_valid = 1'b0;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = with_last && (i == prog.size() - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
  endtask

  // Advance the bench's PC register from the DUT's select outputs, as the PC stage would.
  task automatic follow();
    int pc_n;
    case (jmpCond)
      2'b00:   pc_n = (pc + 1) % 256;
      2'b01:   pc_n = int'(jAddr);
      2'b10:   pc_n = int'(instr[17:10]);
      default: pc_n = 0;
    endcase
    tick();
    pc = pc_n;
    Addr_instr = 8'(pc);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[5];
    seq = '{0, 1, 2, 0, 1};

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check_en = 1'b1;
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_prog_len", 32'(prog_len), 32'd0);
    chk("reset_load_ready", 32'(load_ready), 32'd0);
    chk("reset_jmpCond", 32'(jmpCond), 32'd3);
    chk("reset_instr", 32'(instr), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Three-word program, sequential run with wrap
    prog = {mk(5'h01, 8'd0), mk(5'h02, 8'd0), mk(5'h03, 8'd0)};
    Addr_instr = 8'd0;
    pc = 0;
    load_prog(1'b1);
    #2;
    chk("run_after_load", 32'(running), 32'd1);
    chk("len3", 32'(prog_len), 32'd3);
    chk("model_len3", 32'(m_len), 32'd3);
    for (int k = 0; k < 5; k++) begin
      chk("pc_seq", 32'(pc), 32'(seq[k]));
      if (k == 2) chk("wrap_jc", 32'(jmpCond), 32'd3);
      follow();
    end

    // JGZ with clamped target
    prog = {mk(5'h01, 8'd0), mk(5'h0B, 8'd5), mk(5'h02, 8'd0)};
    load_prog(1'b1);
    Addr_instr = 8'd1;
    acc = 11'd7;
    #2;
    chk("jgz_taken_jc", 32'(jmpCond), 32'd1);
    chk("jgz_taken_ja", 32'(jAddr), 32'd2);
    acc = 11'h7FC;
    #1;
    chk("jgz_not_taken_jc", 32'(jmpCond), 32'd0);

    // JRO negative clamp and positive offset
    acc = 11'd0;
    prog = {mk(5'h01, 8'd0), mk(5'h0D, 8'hFC), mk(5'h02, 8'd0), mk(5'h03, 8'd0)};
    load_prog(1'b1);
    Addr_instr = 8'd1;
    #2;
    chk("jro_neg_jc", 32'(jmpCond), 32'd1);
    chk("jro_neg_ja", 32'(jAddr), 32'd0);
    prog[1] = mk(5'h0D, 8'd2);
    load_prog(1'b1);
    Addr_instr = 8'd1;
    #2;
    chk("jro_pos_ja", 32'(jAddr), 32'd3);

    // Stall hold at address 2
    prog = {mk(5'h01, 8'd0), mk(5'h02, 8'd0), mk(5'h03, 8'd0), mk(5'h04, 8'd0), mk(5'h05, 8'd0)};
    load_prog(1'b1);
    pc = 0;
    Addr_instr = 8'd0;
    #2;
    follow();
    follow();
    chk("stall_pre_pc", 32'(pc), 32'd2);
    port_stall = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_jc", 32'(jmpCond), 32'd1);
      chk("stall_ja", 32'(jAddr), 32'd2);
      follow();
      chk("stall_pc", 32'(pc), 32'd2);
    end
    port_stall = 1'b0;
    #1;
    follow();
    chk("stall_resume_pc", 32'(pc), 32'd3);

    // Overflow: DEPTH+2 words, no load_last
    prog = {};
    for (int i = 0; i < DEPTH + 2; i++) prog.push_back(mk(5'($urandom_range(1, 7)), 8'($urandom)));
    load_prog(1'b0);
    #2;
    chk("ovf_load_ready", 32'(load_ready), 32'd0);
    chk("ovf_running", 32'(running), 32'd1);
    chk("ovf_prog_len", 32'(prog_len), 32'd16);
    Addr_instr = 8'd0;
    #1;
    chk("ovf_word0_kept", 32'(instr), 32'(prog[0]));
    Addr_instr = 8'd15;
    #1;
    chk("ovf_word15", 32'(instr), 32'(prog[15]));

    // load_start mid-run at address 5
    tick();
    Addr_instr = 8'd5;
    pc = 5;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    #2;
    chk("abort_running", 32'(running), 32'd0);
    chk("abort_jc", 32'(jmpCond), 32'd3);
    chk("abort_load_ready", 32'(load_ready), 32'd1);
    follow();
    chk("abort_pc", 32'(pc), 32'd0);

    // Asynchronous reset mid-load
    load_valid = 1'b1;
    load_data  = mk(5'h01, 8'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_load_ready", 32'(load_ready), 32'd0);
    chk("areset_running", 32'(running), 32'd0);
    chk("areset_prog_len", 32'(prog_len), 32'd0);
    load_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset from RUN clears prog_len without a clock edge
    prog = {mk(5'h01, 8'd0), mk(5'h02, 8'd0), mk(5'h03, 8'd0)};
    load_prog(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_run_len", 32'(prog_len), 32'd0);
    chk("areset_run_running", 32'(running), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-word program always wraps
    prog = {mk(5'h01, 8'd0)};
    load_prog(1'b1);
    pc = 0;
    Addr_instr = 8'd0;
    #2;
    chk("len1_jc", 32'(jmpCond), 32'd3);
    follow();
    chk("len1_pc", 32'(pc), 32'd0);

    // Randomized traffic checked by the per-cycle compare
    for (int it = 0; it < 30; it++) begin
      int L;
      bit with_last;
      int i;
      L = $urandom_range(1, DEPTH + 2);
      with_last = (L <= DEPTH) && ($urandom_range(0, 3) != 0);
      prog = {};
      for (int j = 0; j < L; j++) begin
        logic [4:0] op;
        logic [7:0] imm;
        case ($urandom_range(0, 8))
          0: op = 5'h00;
          1: op = 5'h08;
          2: op = 5'h09;
          3: op = 5'h0A;
          4: op = 5'h0B;
          5: op = 5'h0C;
          6: op = 5'h0D;
          7: op = 5'h01;
          default: op = 5'($urandom);
        endcase
        imm = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, L + 2)) : 8'($urandom);
        prog.push_back(mk(op, imm));
      end
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      i = 0;
      while (i < L) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = prog[i];
        load_last  = with_last && (i == L - 1);
        tick();
        if (load_valid) i++;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      pc = 0;
      Addr_instr = 8'd0;
      #2;
      for (int c = 0; c < 40; c++) begin
        case ($urandom_range(0, 3))
          0: acc = 11'd0;
          1: acc = 11'($urandom_range(1, 5));
          2: acc = 11'(-$urandom_range(1, 5));
          default: acc = 11'($urandom);
        endcase
        port_stall = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 7) == 0) begin
          pc = $urandom_range(0, 255);
          Addr_instr = 8'(pc);
        end
        load_start = ($urandom_range(0, 59) == 0);
        #1;
        follow();
        load_start = 1'b0;
      end
      port_stall = 1'b0;
    end

    tick();
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
